// File: rtl/alu_writeback_stage.sv
// Write-back stage behind the ALU: 2-entry skid buffer, architectural flag register,
// condition-code predication of the register-file write, and a retired-instruction counter.
module alu_writeback_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_result,
    input  logic [3:0]            in_flags,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wr_en,
    input  logic                  in_set_flags,
    input  logic [2:0]            in_cond,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_wr_en,
    output logic [3:0]            flags_q,
    output logic [CNT_W-1:0]      retired_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t                  state, state_nxt;
    logic [DATA_W-1:0]       skid_result;
    logic [REG_ADDR_W-1:0]   skid_rd;
    logic                    skid_wr_en;
    logic                    accept, oxfer, cond_true, new_wr_en;
    logic                    load_main, load_skid, skid_to_main;

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign oxfer     = out_valid & out_ready;

    // flags_q is the pre-edge value, so a back-to-back instruction sees the previous update
    always_comb begin
        cond_true = 1'b0;
        case (in_cond)
            3'd0: cond_true = 1'b1;
            3'd1: cond_true = flags_q[2];
            3'd2: cond_true = ~flags_q[2];
            3'd3: cond_true = flags_q[3] ^ flags_q[0];
            3'd4: cond_true = ~(flags_q[3] ^ flags_q[0]);
            3'd5: cond_true = flags_q[1];
            3'd6: cond_true = ~flags_q[1];
            default: cond_true = 1'b0;
        endcase
    end

    assign new_wr_en = in_wr_en & (in_rd != '0) & cond_true;

    always_comb begin
        state_nxt    = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state)
            EMPTY: if (accept) begin
                state_nxt = ONE;
                load_main = 1'b1;
            end
            ONE: begin
                if (accept && oxfer) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (oxfer) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: if (oxfer) begin
                skid_to_main = 1'b1;
                state_nxt    = ONE;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            in_ready    <= 1'b1;
            out_result  <= '0;
            out_rd      <= '0;
            out_wr_en   <= 1'b0;
            skid_result <= '0;
            skid_rd     <= '0;
            skid_wr_en  <= 1'b0;
            flags_q     <= 4'b0;
            retired_cnt <= '0;
        end else begin
            state    <= state_nxt;
            // registered ready: no combinational path from out_ready
            in_ready <= (state_nxt != FULL);
            if (load_main) begin
                out_result <= in_result;
                out_rd     <= in_rd;
                out_wr_en  <= new_wr_en;
            end else if (skid_to_main) begin
                out_result <= skid_result;
                out_rd     <= skid_rd;
                out_wr_en  <= skid_wr_en;
            end
            if (load_skid) begin
                skid_result <= in_result;
                skid_rd     <= in_rd;
                skid_wr_en  <= new_wr_en;
            end
            if (accept && cond_true && in_set_flags)
                flags_q <= in_flags;
            if (oxfer)
                retired_cnt <= retired_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed vector table, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_flags;
    logic [4:0]  in_rd;
    logic        in_wr_en, in_set_flags;
    logic [2:0]  in_cond;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wr_en;
    logic [3:0]  flags_q;
    logic [15:0] retired_cnt;

    alu_writeback_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_flags(in_flags), .in_rd(in_rd), .in_wr_en(in_wr_en),
        .in_set_flags(in_set_flags), .in_cond(in_cond),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_wr_en(out_wr_en), .flags_q(flags_q),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wr_en;
    } ent_t;

    typedef struct {
        logic       sf;
        logic [3:0] fl;
        logic [2:0] cond;
        logic [4:0] rd;
        logic       we;
        logic       exp_we;
        logic [3:0] exp_fl;
    } vec_t;

    ent_t       mq[$];
    logic [3:0] mflags;
    int         mcnt;
    int         n_cmp = 0;
    int         n_err = 0;
    vec_t       tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Condition rules stated with the flags named N,Z,C,V
    function automatic bit cond_ok(input logic [2:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            3'd0: return 1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n != v;
            3'd4: return n == v;
            3'd5: return cy;
            3'd6: return !cy;
            default: return 0;
        endcase
    endfunction

    task automatic check_state();
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("flags_q", 32'(flags_q), 32'(mflags));
        chk("retired_cnt", 32'(retired_cnt), 32'(mcnt));
        if (mq.size() > 0) begin
            chk("out_result", out_result, mq[0].result);
            chk("out_rd", 32'(out_rd), 32'(mq[0].rd));
            chk("out_wr_en", 32'(out_wr_en), 32'(mq[0].wr_en));
        end
    endtask

    // Advance model and DUT across one clock edge using the currently driven inputs
    task automatic step();
        bit   acc, ox, c;
        ent_t e;
        acc = in_valid && (mq.size() < 2);
        ox  = (mq.size() > 0) && out_ready;
        if (ox) begin
            void'(mq.pop_front());
            mcnt = (mcnt + 1) % 65536;
        end
        if (acc) begin
            c        = cond_ok(in_cond, mflags);
            e.result = in_result;
            e.rd     = in_rd;
            e.wr_en  = in_wr_en && (in_rd != 0) && c;
            mq.push_back(e);
            if (c && in_set_flags) mflags = in_flags;
        end
        @(posedge clk); #1;
        check_state();
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
        mq.delete();
        mflags = 4'b0;
        mcnt   = 0;
        check_state();
    endtask

    task automatic drive(input logic [31:0] r, input logic [4:0] rd, input logic we,
                         input logic sf, input logic [3:0] fl, input logic [2:0] c);
        in_valid = 1'b1; in_result = r; in_rd = rd; in_wr_en = we;
        in_set_flags = sf; in_flags = fl; in_cond = c;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_result = '0; in_flags = '0; in_rd = '0; in_wr_en = 1'b0;
        in_set_flags = 1'b0; in_cond = 3'd0;
        mflags = 4'b0; mcnt = 0;

        //            sf    fl       cond  rd     we    exp_we exp_fl
        tbl[0]  = '{1'b1, 4'b0100, 3'd0, 5'd1, 1'b1, 1'b1, 4'b0100};
        tbl[1]  = '{1'b0, 4'b0000, 3'd2, 5'd4, 1'b1, 1'b0, 4'b0100};
        tbl[2]  = '{1'b0, 4'b0000, 3'd1, 5'd5, 1'b1, 1'b1, 4'b0100};
        tbl[3]  = '{1'b1, 4'b1000, 3'd1, 5'd6, 1'b1, 1'b1, 4'b1000};
        tbl[4]  = '{1'b0, 4'b0000, 3'd3, 5'd7, 1'b1, 1'b1, 4'b1000};
        tbl[5]  = '{1'b0, 4'b0000, 3'd4, 5'd7, 1'b1, 1'b0, 4'b1000};
        tbl[6]  = '{1'b1, 4'b0010, 3'd4, 5'd8, 1'b1, 1'b0, 4'b1000};
        tbl[7]  = '{1'b1, 4'b0010, 3'd0, 5'd0, 1'b1, 1'b0, 4'b0010};
        tbl[8]  = '{1'b0, 4'b0000, 3'd5, 5'd9, 1'b1, 1'b1, 4'b0010};
        tbl[9]  = '{1'b0, 4'b0000, 3'd6, 5'd9, 1'b1, 1'b0, 4'b0010};
        tbl[10] = '{1'b0, 4'b0000, 3'd7, 5'd9, 1'b1, 1'b0, 4'b0010};
        tbl[11] = '{1'b1, 4'b1001, 3'd0, 5'd3, 1'b0, 1'b0, 4'b1001};
        tbl[12] = '{1'b0, 4'b0000, 3'd4, 5'd2, 1'b1, 1'b1, 4'b1001};
        tbl[13] = '{1'b0, 4'b0000, 3'd3, 5'd2, 1'b1, 1'b0, 4'b1001};

        // Reset held two cycles
        do_reset(2);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_flags", 32'(flags_q), 0);
        chk("rst_cnt", 32'(retired_cnt), 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_wr_en", 32'(out_wr_en), 0);

        // Single AL push
        out_ready = 1'b1;
        drive(32'h5, 5'd3, 1'b1, 1'b0, 4'b0, 3'd0);
        step();
        chk("push_valid", 32'(out_valid), 1);
        chk("push_result", out_result, 32'h5);
        chk("push_rd", 32'(out_rd), 3);
        chk("push_we", 32'(out_wr_en), 1);
        in_valid = 1'b0;
        step();
        chk("push_cnt", 32'(retired_cnt), 1);

        // Condition/flag vector table, back-to-back at full throughput
        for (int i = 0; i < 14; i++) begin
            drive(32'h100 + i, tbl[i].rd, tbl[i].we, tbl[i].sf, tbl[i].fl, tbl[i].cond);
            step();
            chk($sformatf("tbl%0d_we", i), 32'(out_wr_en), 32'(tbl[i].exp_we));
            chk($sformatf("tbl%0d_flags", i), 32'(flags_q), 32'(tbl[i].exp_fl));
        end
        in_valid = 1'b0;
        step();

        // Backpressure: A, B fill the buffer, C stalls
        out_ready = 1'b0;
        drive(32'hA, 5'd10, 1'b1, 1'b0, 4'b0, 3'd0); step();
        drive(32'hB, 5'd11, 1'b1, 1'b0, 4'b0, 3'd0); step();
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_head", out_result, 32'hA);
        drive(32'hC, 5'd12, 1'b1, 1'b0, 4'b0, 3'd0); step();
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_hold", out_result, 32'hA);
        out_ready = 1'b1;
        step();
        chk("drain_B", out_result, 32'hB);
        step();
        chk("drain_C", out_result, 32'hC);
        in_valid = 1'b0;
        step();
        chk("drain_empty", 32'(out_valid), 0);

        // Reset while FULL discards both entries
        out_ready = 1'b0;
        drive(32'hD0, 5'd1, 1'b1, 1'b1, 4'b1111, 3'd0); step();
        drive(32'hD1, 5'd2, 1'b1, 1'b0, 4'b0, 3'd0); step();
        do_reset(1);
        chk("rstfull_valid", 32'(out_valid), 0);
        chk("rstfull_flags", 32'(flags_q), 0);
        out_ready = 1'b1;
        repeat (3) step();
        chk("rstfull_none", 32'(retired_cnt), 0);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            in_valid     = ($urandom_range(0, 9) < 7);
            out_ready    = ($urandom_range(0, 9) < 6);
            in_result    = $urandom;
            in_rd        = 5'($urandom_range(0, 31));
            in_wr_en     = 1'($urandom);
            in_set_flags = 1'($urandom);
            in_flags     = 4'($urandom);
            in_cond      = 3'($urandom);
            step();
        end

        // Counter wrap: 65535 transfers to 0xFFFF, then one more
        do_reset(1);
        out_ready = 1'b1;
        drive(32'h1, 5'd1, 1'b1, 1'b0, 4'b0, 3'd0);
        for (int i = 0; i < 65536; i++) step();
        chk("cnt_ffff", 32'(retired_cnt), 32'hFFFF);
        step();
        chk("cnt_wrap", 32'(retired_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
